// File: rtl/sync_rr_merge5_arb_if.sv
// Bundle between five token requesters, the 5-to-1 merge arbiter and the single
// downstream update port. Signal names follow the drive/free handshake of the block.
interface sync_rr_merge5_arb_if #(
   parameter int DATA_W = 6
);
   logic              i_drive0;
   logic              i_drive1;
   logic              i_drive2;
   logic              i_drive3;
   logic              i_drive4;
   logic [DATA_W-1:0] i_data0;
   logic [DATA_W-1:0] i_data1;
   logic [DATA_W-1:0] i_data2;
   logic [DATA_W-1:0] i_data3;
   logic [DATA_W-1:0] i_data4;
   logic              o_free0;
   logic              o_free1;
   logic              o_free2;
   logic              o_free3;
   logic              o_free4;
   logic              o_driveNext;
   logic [DATA_W-1:0] o_data;
   logic [2:0]        o_src;
   logic              i_freeNext;

   // The arbiter is the slave of the requesters and the downstream ready.
   modport slave (
      input  i_drive0, i_drive1, i_drive2, i_drive3, i_drive4,
      input  i_data0, i_data1, i_data2, i_data3, i_data4,
      input  i_freeNext,
      output o_free0, o_free1, o_free2, o_free3, o_free4,
      output o_driveNext, o_data, o_src
   );

   modport master (
      output i_drive0, i_drive1, i_drive2, i_drive3, i_drive4,
      output i_data0, i_data1, i_data2, i_data3, i_data4,
      output i_freeNext,
      input  o_free0, o_free1, o_free2, o_free3, o_free4,
      input  o_driveNext, o_data, o_src
   );
endinterface

// File: rtl/sync_rr_merge5_arb.sv
// Clocked 5-to-1 merge of replacement-update tokens onto one downstream channel,
// with round-robin (or fixed) priority and a single full-throughput output register.
module sync_rr_merge5_arb #(
   parameter int DATA_W = 6,
   parameter bit RR_EN  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   sync_rr_merge5_arb_if.slave  bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e            stateQ, stateD;
   logic [DATA_W-1:0] dataQ, dataD;
   logic [2:0]        srcQ, srcD;
   logic [2:0]        rrPtrQ, rrPtrD;

   logic [4:0]        req;
   logic [DATA_W-1:0] dataArr [5];
   logic [4:0]        grant;
   logic [2:0]        grantIdx;
   logic              found;
   logic              load;

   assign req = {bus.i_drive4, bus.i_drive3, bus.i_drive2, bus.i_drive1, bus.i_drive0};

   always_comb begin
      dataArr[0] = bus.i_data0;
      dataArr[1] = bus.i_data1;
      dataArr[2] = bus.i_data2;
      dataArr[3] = bus.i_data3;
      dataArr[4] = bus.i_data4;
   end

   // First requester found walking upward from the search start, wrapping after 4.
   always_comb begin
      logic [3:0] idx;
      logic [2:0] idxS;
      grant    = '0;
      grantIdx = '0;
      found    = 1'b0;
      idx      = '0;
      idxS     = '0;
      for (int k = 0; k < 5; k++) begin
         idx = RR_EN ? ({1'b0, rrPtrQ} + 4'(k)) : 4'(k);
         if (idx >= 4'd5) begin
            idx = idx - 4'd5;
         end
         idxS = idx[2:0];
         if (!found && req[idxS]) begin
            grant[idxS] = 1'b1;
            grantIdx    = idxS;
            found       = 1'b1;
         end
      end
   end

   // The stage can accept whenever it is empty or its token leaves on this edge.
   assign load = rst & ((stateQ == EMPTY) | bus.i_freeNext);

   assign bus.o_free0 = load & grant[0];
   assign bus.o_free1 = load & grant[1];
   assign bus.o_free2 = load & grant[2];
   assign bus.o_free3 = load & grant[3];
   assign bus.o_free4 = load & grant[4];

   always_comb begin
      stateD = stateQ;
      dataD  = dataQ;
      srcD   = srcQ;
      rrPtrD = rrPtrQ;
      if (load) begin
         if (found) begin
            stateD = FULL;
            dataD  = dataArr[grantIdx];
            srcD   = grantIdx;
            if (RR_EN) begin
               rrPtrD = (grantIdx == 3'd4) ? 3'd0 : grantIdx + 3'd1;
            end
         end else begin
            stateD = EMPTY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ <= EMPTY;
         dataQ  <= '0;
         srcQ   <= '0;
         rrPtrQ <= '0;
      end else begin
         stateQ <= stateD;
         dataQ  <= dataD;
         srcQ   <= srcD;
         rrPtrQ <= rrPtrD;
      end
   end

   assign bus.o_driveNext = (stateQ == FULL);
   assign bus.o_data      = dataQ;
   assign bus.o_src       = srcQ;

endmodule

// File: tb/tb_sync_rr_merge5_arb.sv
// Self-checking bench for sync_rr_merge5_arb: a reference model predicts grants and a
// scoreboard queue holds each accepted token until it is seen leaving downstream.
module tb_sync_rr_merge5_arb;

   localparam int DATA_W = 6;

   logic              clk = 1'b0;
   logic              rstN = 1'b1;
   logic [4:0]        drv;
   logic [DATA_W-1:0] dat [5];
   logic              freeNext;
   logic              fpSel;

   int checks = 0;
   int errors = 0;

   bit                mFull;
   logic [2:0]        mPtr;
   logic [8:0]        sbQ [$];

   logic [4:0]        obsFree;
   logic              obsDrive;
   logic [DATA_W-1:0] obsData;
   logic [2:0]        obsSrc;

   sync_rr_merge5_arb_if #(.DATA_W(DATA_W)) rrIf ();
   sync_rr_merge5_arb_if #(.DATA_W(DATA_W)) fpIf ();

   sync_rr_merge5_arb #(.DATA_W(DATA_W), .RR_EN(1'b1)) dutRr (
      .clk (clk),
      .rst (rstN),
      .bus (rrIf)
   );

   sync_rr_merge5_arb #(.DATA_W(DATA_W), .RR_EN(1'b0)) dutFp (
      .clk (clk),
      .rst (rstN),
      .bus (fpIf)
   );

   always #5 clk = ~clk;

   // Only the instance under test sees requests; both share data and downstream ready.
   assign rrIf.i_drive0 = drv[0] & ~fpSel;
   assign rrIf.i_drive1 = drv[1] & ~fpSel;
   assign rrIf.i_drive2 = drv[2] & ~fpSel;
   assign rrIf.i_drive3 = drv[3] & ~fpSel;
   assign rrIf.i_drive4 = drv[4] & ~fpSel;
   assign fpIf.i_drive0 = drv[0] & fpSel;
   assign fpIf.i_drive1 = drv[1] & fpSel;
   assign fpIf.i_drive2 = drv[2] & fpSel;
   assign fpIf.i_drive3 = drv[3] & fpSel;
   assign fpIf.i_drive4 = drv[4] & fpSel;
   assign rrIf.i_data0 = dat[0];
   assign rrIf.i_data1 = dat[1];
   assign rrIf.i_data2 = dat[2];
   assign rrIf.i_data3 = dat[3];
   assign rrIf.i_data4 = dat[4];
   assign fpIf.i_data0 = dat[0];
   assign fpIf.i_data1 = dat[1];
   assign fpIf.i_data2 = dat[2];
   assign fpIf.i_data3 = dat[3];
   assign fpIf.i_data4 = dat[4];
   assign rrIf.i_freeNext = freeNext;
   assign fpIf.i_freeNext = freeNext;

   assign obsFree  = fpSel ? {fpIf.o_free4, fpIf.o_free3, fpIf.o_free2, fpIf.o_free1, fpIf.o_free0}
                           : {rrIf.o_free4, rrIf.o_free3, rrIf.o_free2, rrIf.o_free1, rrIf.o_free0};
   assign obsDrive = fpSel ? fpIf.o_driveNext : rrIf.o_driveNext;
   assign obsData  = fpSel ? fpIf.o_data      : rrIf.o_data;
   assign obsSrc   = fpSel ? fpIf.o_src       : rrIf.o_src;

   task automatic modelReset();
      mFull = 1'b0;
      mPtr  = 3'd0;
      sbQ.delete();
   endtask

   task automatic pulseReset();
      rstN = 1'b0;
      #1;
      rstN = 1'b1;
      modelReset();
   endtask

   // Called just after a falling edge with inputs already applied; returns after the next falling edge.
   task automatic cycle();
      logic [4:0] expFree;
      logic [8:0] expTok;
      int         g;
      bit         load;
      #1;
      load = rstN && (!mFull || freeNext);
      g = -1;
      for (int k = 0; k < 5; k++) begin
         int idx;
         idx = fpSel ? k : (int'(mPtr) + k) % 5;
         if (g < 0 && drv[idx]) g = idx;
      end
      expFree = (load && g >= 0) ? (5'b00001 << g) : 5'b00000;
      checks++;
      if (obsFree !== expFree) begin
         errors++;
         $display("[TB] FAIL free_vector: got %b expected %b", obsFree, expFree);
      end
      checks++;
      if (obsDrive !== mFull) begin
         errors++;
         $display("[TB] FAIL drive_next: got %b expected %b", obsDrive, mFull);
      end
      if (rstN && mFull && freeNext) begin
         checks++;
         if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got token src=%0d data=%0h expected none", obsSrc, obsData);
         end else begin
            expTok = sbQ.pop_front();
            if ({obsSrc, obsData} !== expTok) begin
               errors++;
               $display("[TB] FAIL transfer_token: got src=%0d data=%0h expected src=%0d data=%0h",
                        obsSrc, obsData, expTok[8:6], expTok[5:0]);
            end
         end
      end
      if (load && g >= 0) sbQ.push_back({3'(g), dat[g]});
      if (load) begin
         mFull = (g >= 0);
         if (g >= 0 && !fpSel) mPtr = (g == 4) ? 3'd0 : 3'(g + 1);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      fpSel = 1'b0;
      freeNext = 1'b1;
      drv = 5'b11111;
      for (int k = 0; k < 5; k++) dat[k] = DATA_W'(k + 10);
      modelReset();
      cycle();
      cycle();
      checks++;
      if (obsDrive !== 1'b0) begin errors++; $display("[TB] FAIL reset_drive: got %b expected 0", obsDrive); end
      checks++;
      if (obsData !== 6'd0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", obsData); end
      checks++;
      if (obsSrc !== 3'd0) begin errors++; $display("[TB] FAIL reset_src: got %0d expected 0", obsSrc); end
      checks++;
      if (obsFree !== 5'b00000) begin errors++; $display("[TB] FAIL reset_free: got %b expected 00000", obsFree); end
      rstN = 1'b1;
      cycle();
      checks++;
      if (obsDrive !== 1'b1 || obsSrc !== 3'd0 || obsData !== 6'd10) begin
         errors++;
         $display("[TB] FAIL reset_release: got drive=%b src=%0d data=%0d expected drive=1 src=0 data=10",
                  obsDrive, obsSrc, obsData);
      end
   endtask

   task automatic test_round_robin();
      pulseReset();
      drv = 5'b11111;
      freeNext = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         checks++;
         if (obsSrc !== 3'(i % 5) || obsData !== DATA_W'(i % 5 + 10)) begin
            errors++;
            $display("[TB] FAIL rr_order[%0d]: got src=%0d data=%0d expected src=%0d data=%0d",
                     i, obsSrc, obsData, i % 5, i % 5 + 10);
         end
      end
   endtask

   task automatic test_backpressure();
      drv = 5'b00100;
      cycle();
      checks++;
      if (obsSrc !== 3'd2) begin errors++; $display("[TB] FAIL bp_setup: got src=%0d expected 2", obsSrc); end
      drv = 5'b01010;
      freeNext = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (obsSrc !== 3'd2 || obsData !== 6'd12 || obsDrive !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d]: got src=%0d data=%0d expected src=2 data=12", i, obsSrc, obsData);
         end
      end
      freeNext = 1'b1;
      #1;
      checks++;
      if (obsFree !== 5'b01000) begin errors++; $display("[TB] FAIL bp_release_free: got %b expected 01000", obsFree); end
      cycle();
      checks++;
      if (obsSrc !== 3'd3 || obsData !== 6'd13) begin
         errors++;
         $display("[TB] FAIL bp_release_src: got src=%0d data=%0d expected src=3 data=13", obsSrc, obsData);
      end
   endtask

   task automatic test_drain_idle();
      drv = 5'b00100;
      dat[2] = 6'h2A;
      cycle();
      checks++;
      if (obsDrive !== 1'b1 || obsData !== 6'h2A) begin
         errors++;
         $display("[TB] FAIL drain_token: got drive=%b data=%0h expected drive=1 data=2a", obsDrive, obsData);
      end
      drv = 5'b00000;
      cycle();
      cycle();
      checks++;
      if (obsDrive !== 1'b0 || obsData !== 6'h2A || obsSrc !== 3'd2) begin
         errors++;
         $display("[TB] FAIL drain_idle: got drive=%b data=%0h src=%0d expected drive=0 data=2a src=2",
                  obsDrive, obsData, obsSrc);
      end
      drv = 5'b01001;
      #1;
      checks++;
      if (obsFree !== 5'b01000) begin errors++; $display("[TB] FAIL drain_ptr_free: got %b expected 01000", obsFree); end
      cycle();
      checks++;
      if (obsSrc !== 3'd3) begin errors++; $display("[TB] FAIL drain_ptr_src: got %0d expected 3", obsSrc); end
      dat[2] = 6'd12;
   endtask

   task automatic test_async_reset();
      drv = 5'b10000;
      cycle();
      checks++;
      if (obsSrc !== 3'd4 || obsDrive !== 1'b1) begin
         errors++;
         $display("[TB] FAIL areset_setup: got src=%0d drive=%b expected src=4 drive=1", obsSrc, obsDrive);
      end
      rstN = 1'b0;
      #1;
      checks++;
      if (obsDrive !== 1'b0) begin errors++; $display("[TB] FAIL areset_drop: got %b expected 0", obsDrive); end
      checks++;
      if (obsFree !== 5'b00000) begin errors++; $display("[TB] FAIL areset_free: got %b expected 00000", obsFree); end
      modelReset();
      #1;
      rstN = 1'b1;
      drv = 5'b10001;
      cycle();
      checks++;
      if (obsSrc !== 3'd0 || obsData !== 6'd10) begin
         errors++;
         $display("[TB] FAIL areset_ptr: got src=%0d data=%0d expected src=0 data=10", obsSrc, obsData);
      end
   endtask

   task automatic test_fixed_priority();
      fpSel = 1'b1;
      pulseReset();
      drv = 5'b10010;
      freeNext = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (obsFree !== 5'b00010) begin
            errors++;
            $display("[TB] FAIL fp_free[%0d]: got %b expected 00010", i, obsFree);
         end
         cycle();
         checks++;
         if (obsSrc !== 3'd1) begin errors++; $display("[TB] FAIL fp_src[%0d]: got %0d expected 1", i, obsSrc); end
      end
      drv = 5'b00000;
      fpSel = 1'b0;
      pulseReset();
   endtask

   task automatic test_back_to_back();
      pulseReset();
      for (int k = 0; k < 5; k++) dat[k] = DATA_W'($urandom_range(0, 63));
      for (int i = 0; i < 300; i++) begin
         drv = 5'($urandom_range(0, 31));
         freeNext = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drv = 5'b00000;
      freeNext = 1'b1;
      cycle();
      cycle();
   endtask

   initial begin
      fpSel = 1'b0;
      drv = 5'b00000;
      freeNext = 1'b0;
      for (int k = 0; k < 5; k++) dat[k] = '0;
      rstN = 1'b0;
      modelReset();
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_backpressure();
      test_drain_idle();
      test_async_reset();
      test_fixed_priority();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
